// File: rtl/bit_delay_pkg.sv
// rtl/bit_delay_pkg.sv - shared limits and defaults for the bit delay line
package bit_delay_pkg;

  localparam int unsigned WIDTH_MAX        = 32;
  localparam int unsigned DEPTH_MAX        = 16;
  localparam logic        INIT_VAL_DEFAULT = 1'b0;
  localparam int unsigned VOTE_LEN         = 3;

endpackage

// File: rtl/maj3_voter.sv
// rtl/maj3_voter.sv - three-sample history with 2-of-3 majority (used under BIT_DELAY_MAJORITY_EN)
module maj3_voter
  import bit_delay_pkg::*;
#(
  parameter logic INIT_VAL = INIT_VAL_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic advance,
  input  logic flush,
  input  logic rx,
  output logic vote
);

  logic [VOTE_LEN-1:0] hist;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= {VOTE_LEN{INIT_VAL}};
    end else if (flush) begin
      hist <= {VOTE_LEN{INIT_VAL}};
    end else if (advance) begin
      hist <= {hist[VOTE_LEN-2:0], rx};
    end
  end

  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/bit_delay_line.sv
// rtl/bit_delay_line.sv - per-channel prescaled delay line with fill tracking and edge pulses
// Optional glitch voter in front of each line: define BIT_DELAY_MAJORITY_EN.
module bit_delay_line
  import bit_delay_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned DEPTH    = 1,
  parameter logic        INIT_VAL = INIT_VAL_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Prescale_EN,
  input  logic             flush,
  input  logic [WIDTH-1:0] rx,
  output logic [WIDTH-1:0] puffer,
  output logic             valid,
  output logic [WIDTH-1:0] edge_fall,
  output logic [WIDTH-1:0] edge_rise
);

`ifdef BIT_DELAY_MAJORITY_EN
  // The voter history adds two enable periods before a sample reaches stage0.
  localparam int unsigned FILL = DEPTH + VOTE_LEN - 1;
`else
  localparam int unsigned FILL = DEPTH;
`endif
  localparam int unsigned CNT_W = $clog2(FILL + 1);

  logic [CNT_W-1:0] fill_cnt;
  logic [WIDTH-1:0] stage_in;
  logic [WIDTH-1:0] tail_next;

  genvar ch;
  generate
    for (ch = 0; ch < WIDTH; ch++) begin : g_ch
      logic stage [DEPTH];

`ifdef BIT_DELAY_MAJORITY_EN
      maj3_voter #(
        .INIT_VAL(INIT_VAL)
      ) u_vote (
        .clock  (clock),
        .reset  (reset),
        .advance(Prescale_EN),
        .flush  (flush),
        .rx     (rx[ch]),
        .vote   (stage_in[ch])
      );
`else
      assign stage_in[ch] = rx[ch];
`endif

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= INIT_VAL;
        end else if (flush) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= INIT_VAL;
        end else if (Prescale_EN) begin
          stage[0] <= stage_in[ch];
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign puffer[ch] = stage[DEPTH-1];

      // Value the output stage will take on the next enabled edge.
      if (DEPTH == 1) begin : g_short
        assign tail_next[ch] = stage_in[ch];
      end else begin : g_long
        assign tail_next[ch] = stage[DEPTH-2];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_cnt  <= '0;
      edge_fall <= '0;
      edge_rise <= '0;
    end else if (flush) begin
      fill_cnt  <= '0;
      edge_fall <= '0;
      edge_rise <= '0;
    end else begin
      if (Prescale_EN && (fill_cnt != CNT_W'(FILL))) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (Prescale_EN && valid) begin
        edge_fall <= puffer & ~tail_next;
        edge_rise <= ~puffer & tail_next;
      end else begin
        edge_fall <= '0;
        edge_rise <= '0;
      end
    end
  end

  assign valid = (fill_cnt == CNT_W'(FILL));

endmodule
